// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: state encoding and depth helper.
package fifo_pkg;

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_PARTIAL = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   function automatic int fifo_depth(input int aw);
      return 2 ** aw;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// AW-bit wrapping pointer with synchronous reset and increment enable.
module fifo_ptr #(
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (reset)    ptr <= '0;
      else if (inc) ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving a two-port memory: port A writes, port B reads.
// Define FIFO_CTRL_ERR_EN to enable sticky overflow/underflow detection on error.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int AW    = 3,
   parameter int DW    = 4,
   parameter int AF_TH = 6,
   parameter int AE_TH = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic          pop_valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic [AW:0]   count,
   output logic          error,
   output logic [AW-1:0] mem_addr_a,
   output logic          mem_rw_a,
   output logic [DW-1:0] mem_din_a,
   output logic [AW-1:0] mem_addr_b,
   output logic          mem_rw_b,
   input  logic [DW-1:0] mem_dout_b
);

   localparam int          DEPTH   = fifo_depth(AW);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t        state, state_nxt;
   logic [AW:0]   count_nxt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          push_acc, pop_acc;

   assign empty    = (state == S_EMPTY);
   assign full     = (state == S_FULL);
   assign pop_acc  = pop & ~empty;
   // A full FIFO still takes a push when a pop frees the slot in the same cycle.
   assign push_acc = push & (~full | pop_acc);

   assign mem_rw_a   = push_acc & ~reset;
   assign mem_addr_a = wr_ptr;
   assign mem_din_a  = push_data;
   assign mem_rw_b   = 1'b0;
   assign mem_addr_b = rd_ptr;
   assign pop_data   = mem_dout_b;

   fifo_ptr #(.AW(AW)) u_wr_ptr (.clk(clk), .reset(reset), .inc(push_acc), .ptr(wr_ptr));
   fifo_ptr #(.AW(AW)) u_rd_ptr (.clk(clk), .reset(reset), .inc(pop_acc),  .ptr(rd_ptr));

   assign count_nxt = count + (AW+1)'(push_acc) - (AW+1)'(pop_acc);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_EMPTY;
         count     <= '0;
         pop_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         pop_valid <= pop_acc;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_EMPTY:
            if (push_acc) state_nxt = (DEPTH == 1) ? S_FULL : S_PARTIAL;
         S_PARTIAL:
            if (count_nxt == '0)          state_nxt = S_EMPTY;
            else if (count_nxt == DEPTH_C) state_nxt = S_FULL;
         S_FULL:
            if (pop_acc && !push_acc) state_nxt = (count_nxt == '0) ? S_EMPTY : S_PARTIAL;
         default: state_nxt = S_EMPTY;
      endcase
   end

   assign almost_full  = (count >= (AW+1)'(AF_TH));
   assign almost_empty = (count <= (AW+1)'(AE_TH));

`ifdef FIFO_CTRL_ERR_EN
   logic err_r;
   always_ff @(posedge clk) begin
      if (reset)
         err_r <= 1'b0;
      else if ((push & full & ~pop_acc) | (pop & empty))
         err_r <= 1'b1;
   end
   assign error = err_r;
`else
   assign error = 1'b0;
`endif

endmodule
